// File: rtl/sha_lane_arbiter.sv
// sha_lane_arbiter: round-robin sharing of one SHA-256 core among N_REQ
// byte-stream requesters, with digest compare and tagged result.
`timescale 1ns/1ps
module sha_lane_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 55,
  parameter int TIMEOUT = 1023,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [255:0]       target_hash,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               sha_rst_n,
  output logic               sha_byte_rdy,
  output logic               sha_byte_stop,
  output logic [7:0]         sha_data,
  input  logic               sha_done,
  input  logic               sha_overflow_err,
  input  logic [255:0]       sha_digest,
  output logic               res_valid,
  output logic [ID_W-1:0]    res_id,
  output logic               res_match,
  output logic               res_err,
  output logic [255:0]       res_digest,
  output logic               busy
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_STOP,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t state, state_n;

  logic [ID_W-1:0]  grant, last_grant, pick, cand;
  logic             found;
  logic [255:0]     target;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [TO_W-1:0]  tcnt;
  logic             acc, lane_last, to_hit, wait_end, err_nx;
  logic [7:0]       lane_byte;
  logic [255:0]     dig_nx;
  int               idx;

  // search upward from the slot after the last served requester
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx  = (int'(last_grant) + k) % N_REQ;
      cand = idx[ID_W-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign acc       = (state == S_STREAM) && req_valid[grant];
  assign lane_byte = req_data[{grant, 3'b000} +: 8];
  assign lane_last = req_last[grant];
  assign to_hit    = (tcnt == TO_W'(TIMEOUT));
  assign wait_end  = (state == S_WAIT) &&
                     (sha_done || sha_overflow_err || to_hit);
  assign dig_nx    = sha_done ? sha_digest : '0;
  assign err_nx    = err || sha_overflow_err || (!sha_done && to_hit);

  assign sha_rst_n = (state != S_IDLE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    req_ready = '0;
    if (state == S_STREAM) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (found) state_n = S_STREAM;
      S_STREAM: if (acc && lane_last) state_n = S_STOP;
      S_STOP:   state_n = S_WAIT;
      S_WAIT:   if (wait_end) state_n = S_REPORT;
      S_REPORT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant         <= '0;
      last_grant    <= ID_W'(N_REQ - 1);
      target        <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      tcnt          <= '0;
      sha_data      <= '0;
      sha_byte_rdy  <= 1'b0;
      sha_byte_stop <= 1'b0;
      res_valid     <= 1'b0;
      res_id        <= '0;
      res_match     <= 1'b0;
      res_err       <= 1'b0;
      res_digest    <= '0;
    end else begin
      sha_byte_rdy  <= 1'b0;
      sha_byte_stop <= 1'b0;
      res_valid     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            grant  <= pick;
            target <= target_hash;
            cnt    <= '0;
            err    <= 1'b0;
          end
        end
        S_STREAM: begin
          // bytes past MAX_LEN are swallowed so the sender can finish
          if (acc) begin
            if (cnt < CNT_W'(MAX_LEN)) begin
              sha_data     <= lane_byte;
              sha_byte_rdy <= 1'b1;
              cnt          <= cnt + 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_STOP: begin
          sha_byte_stop <= 1'b1;
          tcnt          <= '0;
        end
        S_WAIT: begin
          if (wait_end) begin
            err        <= err_nx;
            res_valid  <= 1'b1;
            res_id     <= grant;
            res_err    <= err_nx;
            res_digest <= dig_nx;
            res_match  <= (dig_nx == target) && !err_nx;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_REPORT: last_grant <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_lane_arbiter.sv
// tb_sha_lane_arbiter: directed scoreboard bench for sha_lane_arbiter
// with a small SHA core stand-in driven from the main sequence.
`timescale 1ns/1ps
module tb_sha_lane_arbiter;
  localparam int N   = 4;
  localparam int ML  = 55;
  localparam int TO  = 15;
  localparam int IDW = 2;
  localparam logic [255:0] T =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic           clk = 1'b0;
  logic           reset;
  logic [255:0]   target_hash;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           sha_rst_n, sha_byte_rdy, sha_byte_stop;
  logic [7:0]     sha_data;
  logic           sha_done, sha_overflow_err;
  logic [255:0]   sha_digest;
  logic           res_valid;
  logic [IDW-1:0] res_id;
  logic           res_match, res_err;
  logic [255:0]   res_digest;
  logic           busy;
  logic [276:0]   outs;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           match;
    logic           err;
    logic [255:0]   dig;
  } res_t;

  res_t       exp_res[$], got_res[$], mon_r;
  logic [7:0] exp_byte[$], got_byte[$];
  int         got_bcyc[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int rdy_cnt = 0, stop_cnt = 0, acc_cnt = 0, res_cnt = 0, ovl_cnt = 0;
  int stop_cyc = 0, res_cyc = 0, done_cyc = 0, send_t0 = 0;

  sha_lane_arbiter #(.N_REQ(N), .MAX_LEN(ML), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .target_hash(target_hash),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .sha_rst_n(sha_rst_n),
    .sha_byte_rdy(sha_byte_rdy), .sha_byte_stop(sha_byte_stop),
    .sha_data(sha_data), .sha_done(sha_done),
    .sha_overflow_err(sha_overflow_err), .sha_digest(sha_digest),
    .res_valid(res_valid), .res_id(res_id), .res_match(res_match),
    .res_err(res_err), .res_digest(res_digest), .busy(busy)
  );

  assign outs = {busy, sha_rst_n, sha_byte_rdy, sha_byte_stop, sha_data,
                 req_ready, res_valid, res_id, res_match, res_err,
                 res_digest};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if ((req_valid & req_ready) != '0) acc_cnt++;
      if (sha_byte_rdy) begin
        rdy_cnt++;
        got_byte.push_back(sha_data);
        got_bcyc.push_back(cyc);
      end
      if (sha_byte_stop) begin
        stop_cnt++;
        stop_cyc = cyc;
        if (sha_byte_rdy) ovl_cnt++;
      end
      if (res_valid) begin
        mon_r.id    = res_id;
        mon_r.match = res_match;
        mon_r.err   = res_err;
        mon_r.dig   = res_digest;
        got_res.push_back(mon_r);
        res_cnt++;
        res_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [276:0] obs,
                     input logic [276:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input int id, input logic m,
                              input logic e, input logic [255:0] d);
    res_t r;
    r.id = IDW'(id); r.match = m; r.err = e; r.dig = d;
    return r;
  endfunction

  task automatic check_bytes();
    int n;
    chk("byte_count", got_byte.size(), exp_byte.size());
    n = (got_byte.size() < exp_byte.size()) ? got_byte.size()
                                             : exp_byte.size();
    for (int i = 0; i < n; i++) chk("byte_value", got_byte[i], exp_byte[i]);
    got_byte.delete(); got_bcyc.delete(); exp_byte.delete();
  endtask

  task automatic check_results();
    res_t e, g;
    logic have;
    while (exp_res.size() > 0) begin
      have = (got_res.size() > 0);
      chk("res_present", have, 1'b1);
      if (!have) begin
        exp_res.delete();
        break;
      end
      e = exp_res.pop_front();
      g = got_res.pop_front();
      chk("res_id", g.id, e.id);
      chk("res_match", g.match, e.match);
      chk("res_err", g.err, e.err);
      chk("res_digest", g.dig, e.dig);
    end
    chk("res_extra", got_res.size(), 0);
    got_res.delete();
  endtask

  task automatic wait_res(input int n0);
    int k = 0;
    logic got;
    while (res_cnt == n0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    got = (res_cnt != n0);
    chk("res_wait", got, 1'b1);
    check_results();
    check_bytes();
  endtask

  // mode 0: done, 1: silent, 2: overflow together with done
  task automatic core(input int mode, input logic [255:0] dig,
                      input int dly);
    int k = 0;
    logic ok;
    while (!sha_byte_stop && k < 200) begin
      @(posedge clk); #1; k++;
    end
    ok = sha_byte_stop;
    chk("stop_seen", ok, 1'b1);
    if (mode != 1) begin
      repeat (dly) begin @(posedge clk); #1; end
      sha_done = 1'b1;
      sha_overflow_err = (mode == 2);
      sha_digest = dig;
      done_cyc = cyc;
      @(posedge clk); #1;
      sha_done = 1'b0;
      sha_overflow_err = 1'b0;
    end
  endtask

  task automatic send(input int id, input logic [7:0] msg[$],
                      input int gap_at, input int gap_len);
    int k, c0;
    logic ok;
    send_t0 = cyc;
    for (int i = 0; i < msg.size(); i++) begin
      if (i == gap_at) begin
        req_valid[id] = 1'b0;
        @(posedge clk); #1;
        c0 = rdy_cnt;
        repeat (gap_len - 1) begin @(posedge clk); #1; end
        chk("gap_no_strobe", rdy_cnt, c0);
      end
      req_valid[id] = 1'b1;
      req_data[id*8 +: 8] = msg[i];
      req_last[id] = (i == msg.size() - 1);
      if (i < ML) exp_byte.push_back(msg[i]);
      k = 0;
      while (!req_ready[id] && k < 100) begin
        @(posedge clk); #1; k++;
      end
      ok = req_ready[id];
      chk("ready_seen", ok, 1'b1);
      if (!ok) break;
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
    req_last[id] = 1'b0;
  endtask

  initial begin
    logic [7:0] m[$];
    int order[5];
    int k, gid, r0, a0, s0;
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    target_hash = T;
    req_valid = '0; req_last = '0; req_data = '0;
    sha_done = 1'b0; sha_overflow_err = 1'b0; sha_digest = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < N; i++) req_data[i*8 +: 8] = 8'(8'hA0 + i);
    req_valid = '1; req_last = '1;
    for (int it = 0; it < 5; it++) begin
      k = 0;
      while (req_ready == '0 && k < 50) begin @(posedge clk); #1; k++; end
      gid = -1;
      for (int j = 0; j < N; j++) if (req_ready[j]) gid = j;
      chk("rr_grant", gid, order[it]);
      exp_byte.push_back(8'(8'hA0 + gid));
      exp_res.push_back(mk(gid, 1'b1, 1'b0, T));
      r0 = res_cnt;
      @(posedge clk); #1;
      if (it == 4) begin req_valid = '0; req_last = '0; end
      core(0, T, 1);
      wait_res(r0);
    end

    m = '{8'h61, 8'h62, 8'h63};
    exp_res.push_back(mk(0, 1'b1, 1'b0, T));
    r0 = res_cnt; s0 = stop_cnt;
    send(0, m, -1, 0);
    core(0, T, 2);
    wait_res(r0);
    chk("abc_done_to_res", res_cyc - done_cyc, 1);
    chk("abc_idle_after", busy, 1'b0);
    chk("abc_stop_count", stop_cnt - s0, 1);
    m = '{8'h61, 8'h62, 8'h63};
    send(0, m, -1, 0);
    exp_res.push_back(mk(0, 1'b1, 1'b0, T));
    r0 = res_cnt;
    chk("abc_first_strobe",
        got_bcyc.size() > 0 ? got_bcyc[0] - send_t0 : -1, 2);
    chk("abc_stop_after_last",
        got_bcyc.size() > 0 ? 0 : -1, 0);
    core(0, T, 0);
    chk("abc_stop_latency", stop_cyc - got_bcyc[got_bcyc.size()-1], 1);
    wait_res(r0);

    m.delete();
    for (int i = 0; i < 60; i++) m.push_back(8'(i + 1));
    exp_res.push_back(mk(2, 1'b0, 1'b1, T));
    r0 = res_cnt; a0 = acc_cnt;
    send(2, m, -1, 0);
    core(0, T, 1);
    wait_res(r0);
    chk("ovl_accepted", acc_cnt - a0, 60);

    m = '{8'h31, 8'h32, 8'h33, 8'h34};
    exp_res.push_back(mk(3, 1'b0, 1'b1, '0));
    r0 = res_cnt;
    send(3, m, -1, 0);
    core(1, T, 0);
    wait_res(r0);
    chk("timeout_latency", res_cyc - stop_cyc, TO + 1);

    m = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77};
    exp_res.push_back(mk(1, 1'b0, 1'b0, T ^ 256'h1));
    r0 = res_cnt;
    send(1, m, 4, 5);
    core(0, T ^ 256'h1, 3);
    wait_res(r0);

    m = '{8'h5A};
    exp_res.push_back(mk(0, 1'b0, 1'b1, T));
    r0 = res_cnt;
    send(0, m, -1, 0);
    core(2, T, 1);
    wait_res(r0);

    req_valid[2] = 1'b1; req_data[23:16] = 8'h55; req_last[2] = 1'b0;
    k = 0;
    while (!req_ready[2] && k < 20) begin @(posedge clk); #1; k++; end
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("mid_reset_outs", outs, '0);
    @(posedge clk); #1;
    got_byte.delete(); got_bcyc.delete(); exp_byte.delete();
    reset = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*8 +: 8] = 8'(8'h10 + i);
    req_valid = '1; req_last = '1;
    @(posedge clk); #1;
    chk("post_reset_grant", req_ready, 4'b0001);
    exp_byte.push_back(8'h10);
    exp_res.push_back(mk(0, 1'b1, 1'b0, T));
    r0 = res_cnt;
    @(posedge clk); #1;
    req_valid = '0; req_last = '0;
    core(0, T, 2);
    wait_res(r0);

    chk("rdy_stop_overlap", ovl_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
